// File: rtl/csr_unit_irq.sv
// Machine-mode CSR file: mstatus MIE/MPIE stacking, trap entry/mret, prioritised
// interrupt request, 64-bit mcycle/minstret and illegal-access detection.
module csr_unit_irq #(
    parameter int              XLEN         = 32,
    parameter int              IRQ_W        = 16,
    parameter int              HAS_COUNTERS = 1,
    parameter logic [XLEN-1:0] MTVEC_RESET  = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [2:0]      op_i,
    input  logic [11:0]     addr_i,
    input  logic [XLEN-1:0] wd_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] mcause_i,
    input  logic            mret_i,
    input  logic            instr_retired_i,
    input  logic [IRQ_W-1:0] irq_i,
    output logic [XLEN-1:0] rd_o,
    output logic [XLEN-1:0] mepc_o,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mie_o,
    output logic            irq_req_o,
    output logic [XLEN-1:0] irq_cause_o,
    output logic            illegal_o
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYC     = 12'hB00;
    localparam logic [11:0] A_MCYCH    = 12'hB80;
    localparam logic [11:0] A_MINST    = 12'hB02;
    localparam logic [11:0] A_MINSTH   = 12'hB82;

    localparam bit              CNT_EN     = (HAS_COUNTERS != 0);
    localparam bit              CNT_HI     = (HAS_COUNTERS != 0) && (XLEN == 32);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic             r_st_mie;
    logic             r_st_mpie;
    logic [IRQ_W-1:0] r_mie_en;
    logic [IRQ_W-1:0] r_mip;
    logic [XLEN-1:0]  r_mtvec;
    logic [XLEN-1:0]  r_mscratch;
    logic [XLEN-1:0]  r_mepc;
    logic [XLEN-1:0]  r_mcause;
    logic [63:0]      r_mcycle;
    logic [63:0]      r_minstret;

    logic [XLEN-1:0]  w_mstatus;
    logic [XLEN-1:0]  w_mie_full;
    logic [XLEN-1:0]  w_mip_full;
    logic [XLEN-1:0]  w_rd;
    logic             w_mapped;
    logic             w_csr_op;
    logic             w_illegal;
    logic             w_wr;
    logic             w_trap;
    logic [XLEN-1:0]  w_wdata;
    logic [IRQ_W-1:0] w_pend;
    logic             w_found;
    logic [7:0]       w_code;
    logic [XLEN-1:0]  w_cause;

    // Architectural views of the sparse registers
    always_comb begin
        w_mstatus                = '0;
        w_mstatus[3]             = r_st_mie;
        w_mstatus[7]             = r_st_mpie;
        w_mie_full               = '0;
        w_mie_full[16 +: IRQ_W]  = r_mie_en;
        w_mip_full               = '0;
        w_mip_full[16 +: IRQ_W]  = r_mip;
    end

    // Address decode and read mux
    always_comb begin
        w_rd     = '0;
        w_mapped = 1'b1;
        case (addr_i)
            A_MSTATUS:  w_rd = w_mstatus;
            A_MIE:      w_rd = w_mie_full;
            A_MTVEC:    w_rd = r_mtvec & ALIGN_MASK;
            A_MSCRATCH: w_rd = r_mscratch;
            A_MEPC:     w_rd = r_mepc & ALIGN_MASK;
            A_MCAUSE:   w_rd = r_mcause;
            A_MIP:      w_rd = w_mip_full;
            A_MCYC:     if (CNT_EN) w_rd = r_mcycle[XLEN-1:0];   else w_mapped = 1'b0;
            A_MINST:    if (CNT_EN) w_rd = r_minstret[XLEN-1:0]; else w_mapped = 1'b0;
            A_MCYCH:    if (CNT_HI) w_rd = XLEN'(r_mcycle[63:32]);   else w_mapped = 1'b0;
            A_MINSTH:   if (CNT_HI) w_rd = XLEN'(r_minstret[63:32]); else w_mapped = 1'b0;
            default:    w_mapped = 1'b0;
        endcase
    end

    // Op qualification and read-modify-write operand
    always_comb begin
        w_trap    = op_i[2];
        w_csr_op  = ~op_i[2] && (op_i[1:0] != 2'b00);
        w_illegal = w_csr_op && (!w_mapped || (addr_i == A_MIP));
        w_wr      = w_csr_op && !w_illegal;
        case (op_i[1:0])
            2'b01:   w_wdata = wd_i;
            2'b10:   w_wdata = w_rd & ~wd_i;
            2'b11:   w_wdata = w_rd | wd_i;
            default: w_wdata = w_rd;
        endcase
    end

    // CSR state: trap entry beats mret, mret beats a CSR write to mstatus
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_st_mie   <= 1'b0;
            r_st_mpie  <= 1'b0;
            r_mie_en   <= '0;
            r_mip      <= '0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
        end else begin
            r_mip <= irq_i;
            if (w_trap) begin
                r_mepc    <= pc_i & ALIGN_MASK;
                r_mcause  <= mcause_i;
                r_st_mpie <= r_st_mie;
                r_st_mie  <= 1'b0;
            end else begin
                if (w_wr) begin
                    case (addr_i)
                        A_MSTATUS: begin
                            r_st_mie  <= w_wdata[3];
                            r_st_mpie <= w_wdata[7];
                        end
                        A_MIE:      r_mie_en   <= w_wdata[16 +: IRQ_W];
                        A_MTVEC:    r_mtvec    <= w_wdata & ALIGN_MASK;
                        A_MSCRATCH: r_mscratch <= w_wdata;
                        A_MEPC:     r_mepc     <= w_wdata & ALIGN_MASK;
                        A_MCAUSE:   r_mcause   <= w_wdata;
                        default:    ;
                    endcase
                end
                if (mret_i) begin
                    r_st_mie  <= r_st_mpie;
                    r_st_mpie <= 1'b1;
                end
            end
        end
    end

    // Counters: a write to either half freezes that counter for the cycle
    always_ff @(posedge clk_i) begin
        if (rst_i || !CNT_EN) begin
            r_mcycle   <= 64'd0;
            r_minstret <= 64'd0;
        end else begin
            if (w_wr && addr_i == A_MCYC)
                r_mcycle[XLEN-1:0] <= w_wdata;
            else if (w_wr && addr_i == A_MCYCH)
                r_mcycle[63:32] <= w_wdata[31:0];
            else
                r_mcycle <= r_mcycle + 64'd1;

            if (w_wr && addr_i == A_MINST)
                r_minstret[XLEN-1:0] <= w_wdata;
            else if (w_wr && addr_i == A_MINSTH)
                r_minstret[63:32] <= w_wdata[31:0];
            else if (instr_retired_i)
                r_minstret <= r_minstret + 64'd1;
        end
    end

    // Lowest-index pending and enabled line wins
    always_comb begin
        w_pend  = r_mip & r_mie_en;
        w_found = 1'b0;
        w_code  = 8'd0;
        for (int k = IRQ_W - 1; k >= 0; k--) begin
            w_code  = w_pend[k] ? 8'(16 + k) : w_code;
            w_found = w_found | w_pend[k];
        end
        w_cause = '0;
        if (w_found) begin
            w_cause[XLEN-1] = 1'b1;
            w_cause[7:0]    = w_code;
        end else begin
            w_cause = '0;
        end
    end

    assign rd_o        = w_rd;
    assign mepc_o      = r_mepc;
    assign mtvec_o     = r_mtvec;
    assign mie_o       = w_mie_full;
    assign irq_req_o   = r_st_mie & (|w_pend);
    assign irq_cause_o = w_cause;
    assign illegal_o   = w_illegal;

endmodule

// File: tb/tb_csr_unit_irq.sv
// Scoreboard bench for csr_unit_irq: expectations are queued as stimulus is
// driven and checked against the DUT outputs when drained.
module tb_csr_unit_irq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  op_i = 3'b000;
    logic [11:0] addr_i = 12'h000;
    logic [31:0] wd_i = 32'd0;
    logic [31:0] pc_i = 32'd0;
    logic [31:0] mcause_i = 32'd0;
    logic        mret_i = 1'b0;
    logic        instr_retired_i = 1'b0;
    logic [15:0] irq_i = 16'd0;
    logic [31:0] rd_o, mepc_o, mtvec_o, mie_o, irq_cause_o;
    logic        irq_req_o, illegal_o;

    int n_tests = 0;
    int n_fail  = 0;

    localparam int K_RD = 0, K_REQ = 1, K_CAUSE = 2, K_ILL = 3, K_MEPC = 4, K_MTVEC = 5, K_MIE = 6;

    typedef struct {
        string       tag;
        int          kind;
        logic [11:0] addr;
        logic [31:0] exp;
    } sb_t;

    sb_t sb[$];

    csr_unit_irq #(.XLEN(32), .IRQ_W(16), .HAS_COUNTERS(1), .MTVEC_RESET(32'h0000_0100)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .addr_i(addr_i), .wd_i(wd_i),
        .pc_i(pc_i), .mcause_i(mcause_i), .mret_i(mret_i), .instr_retired_i(instr_retired_i),
        .irq_i(irq_i), .rd_o(rd_o), .mepc_o(mepc_o), .mtvec_o(mtvec_o), .mie_o(mie_o),
        .irq_req_o(irq_req_o), .irq_cause_o(irq_cause_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int kind, input logic [11:0] addr, input logic [31:0] exp);
        sb_t e;
        e.tag = tag; e.kind = kind; e.addr = addr; e.exp = exp;
        sb.push_back(e);
    endtask

    // Keep at most five entries per drain so checks finish before the next edge.
    task automatic drain();
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.kind == K_RD) begin
                op_i = 3'b000;
                addr_i = e.addr;
            end
            #1;
            case (e.kind)
                K_RD:    chk(e.tag, rd_o, e.exp);
                K_REQ:   chk(e.tag, {31'd0, irq_req_o}, e.exp);
                K_CAUSE: chk(e.tag, irq_cause_o, e.exp);
                K_ILL:   chk(e.tag, {31'd0, illegal_o}, e.exp);
                K_MEPC:  chk(e.tag, mepc_o, e.exp);
                K_MTVEC: chk(e.tag, mtvec_o, e.exp);
                default: chk(e.tag, mie_o, e.exp);
            endcase
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wd, input logic mret);
        @(negedge clk_i);
        op_i = op; addr_i = addr; wd_i = wd; mret_i = mret;
        @(posedge clk_i);
        #1;
        op_i = 3'b000; mret_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        push("rst_mtvec", K_RD, 12'h305, 32'h0000_0100);
        push("rst_mstatus", K_RD, 12'h300, 32'h0);
        push("rst_mip", K_RD, 12'h344, 32'h0);
        push("rst_mepc", K_RD, 12'h341, 32'h0);
        push("rst_ill_read", K_ILL, 12'h000, 32'h0);
        drain();
        push("rst_req", K_REQ, 12'h000, 32'h0);
        push("rst_cause", K_CAUSE, 12'h000, 32'h0);
        push("rst_mtvec_o", K_MTVEC, 12'h000, 32'h0000_0100);
        drain();

        // mscratch write / clear / set
        do_op(3'b001, 12'h340, 32'hFFFF_00FF, 1'b0);
        push("scr_write", K_RD, 12'h340, 32'hFFFF_00FF); drain();
        do_op(3'b010, 12'h340, 32'h0000_000F, 1'b0);
        push("scr_clear", K_RD, 12'h340, 32'hFFFF_00F0); drain();
        do_op(3'b011, 12'h340, 32'h1234_0000, 1'b0);
        push("scr_set", K_RD, 12'h340, 32'hFFFF_00F0); drain();
        do_op(3'b001, 12'h305, 32'h0000_0207, 1'b0);
        push("mtvec_align", K_RD, 12'h305, 32'h0000_0204); drain();

        // MIE stacking across trap and mret
        do_op(3'b011, 12'h300, 32'h0000_0008, 1'b0);
        push("mstatus_set", K_RD, 12'h300, 32'h0000_0008); drain();
        @(negedge clk_i);
        pc_i = 32'h0000_0203; mcause_i = 32'h0000_000B;
        do_op(3'b100, 12'h340, 32'h0000_0000, 1'b0);
        push("trap_mepc", K_RD, 12'h341, 32'h0000_0200);
        push("trap_mepc_o", K_MEPC, 12'h000, 32'h0000_0200);
        push("trap_mcause", K_RD, 12'h342, 32'h0000_000B);
        push("trap_mstatus", K_RD, 12'h300, 32'h0000_0080);
        push("trap_no_write", K_RD, 12'h340, 32'hFFFF_00F0);
        drain();
        do_op(3'b000, 12'h000, 32'h0, 1'b1);
        push("mret_mstatus", K_RD, 12'h300, 32'h0000_0088); drain();

        // Interrupt priority path
        do_op(3'b001, 12'h304, 32'hFFFF_FFFF, 1'b0);
        push("mie_mask", K_RD, 12'h304, 32'hFFFF_0000); drain();
        do_op(3'b001, 12'h304, 32'h000A_0000, 1'b0);
        push("mie_o", K_MIE, 12'h000, 32'h000A_0000); drain();
        @(negedge clk_i);
        irq_i = 16'h000A;
        step();
        step();
        push("irq_req", K_REQ, 12'h000, 32'h1);
        push("irq_cause17", K_CAUSE, 12'h000, 32'h8000_0011);
        push("mip_read", K_RD, 12'h344, 32'h000A_0000);
        drain();
        do_op(3'b010, 12'h304, 32'h0002_0000, 1'b0);
        push("irq_cause19", K_CAUSE, 12'h000, 32'h8000_0013);
        push("irq_req_still", K_REQ, 12'h000, 32'h1);
        drain();
        do_op(3'b010, 12'h300, 32'h0000_0008, 1'b0);
        push("irq_req_off", K_REQ, 12'h000, 32'h0);
        push("mie_cleared", K_RD, 12'h300, 32'h0000_0080);
        drain();
        @(negedge clk_i);
        irq_i = 16'h0000;
        step();
        push("irq_gone_cause", K_CAUSE, 12'h000, 32'h0); drain();

        // Trap wins over mret; mret wins over an mstatus write
        do_op(3'b011, 12'h300, 32'h0000_0008, 1'b0);
        do_op(3'b100, 12'h000, 32'h0, 1'b1);
        push("trap_over_mret", K_RD, 12'h300, 32'h0000_0080); drain();
        do_op(3'b001, 12'h300, 32'h0000_0000, 1'b1);
        push("mret_over_write", K_RD, 12'h300, 32'h0000_0088); drain();

        // minstret counting
        do_op(3'b001, 12'hB02, 32'h0000_0005, 1'b0);
        @(negedge clk_i);
        instr_retired_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        instr_retired_i = 1'b0;
        push("minstret_cnt", K_RD, 12'hB02, 32'h0000_0008);
        push("minstret_hi", K_RD, 12'hB82, 32'h0);
        drain();

        // mcycle carry into the high half
        do_op(3'b001, 12'hB00, 32'hFFFF_FFFE, 1'b0);
        do_op(3'b001, 12'hB80, 32'h0000_0000, 1'b0);
        push("cyc_lo_hold", K_RD, 12'hB00, 32'hFFFF_FFFE);
        push("cyc_hi_w", K_RD, 12'hB80, 32'h0);
        drain();
        step();
        push("cyc_lo_ff", K_RD, 12'hB00, 32'hFFFF_FFFF); drain();
        step();
        push("cyc_lo_wrap", K_RD, 12'hB00, 32'h0);
        push("cyc_hi_carry", K_RD, 12'hB80, 32'h0000_0001);
        push("minstret_idle", K_RD, 12'hB02, 32'h0000_0008);
        drain();

        // Illegal accesses leave state alone
        @(negedge clk_i);
        op_i = 3'b001; addr_i = 12'h344; wd_i = 32'hFFFF_FFFF;
        push("ill_mip_wr", K_ILL, 12'h000, 32'h1); drain();
        addr_i = 12'h7C0;
        push("ill_unmapped", K_ILL, 12'h000, 32'h1); drain();
        op_i = 3'b011; addr_i = 12'h340; wd_i = 32'h0000_0000;
        push("legal_set", K_ILL, 12'h000, 32'h0); drain();
        op_i = 3'b011; addr_i = 12'h344; wd_i = 32'hFFFF_FFFF;
        @(posedge clk_i);
        #1;
        op_i = 3'b000;
        push("ill_mip_keep", K_RD, 12'h344, 32'h0);
        push("ill_unmapped_rd", K_RD, 12'h7C0, 32'h0);
        push("ill_scr_keep", K_RD, 12'h340, 32'hFFFF_00F0);
        drain();

        // Reset mid-sequence
        do_op(3'b001, 12'h341, 32'h0000_1234, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        step();
        push("rst2_mtvec", K_RD, 12'h305, 32'h0000_0100);
        push("rst2_scr", K_RD, 12'h340, 32'h0);
        push("rst2_mepc", K_RD, 12'h341, 32'h0);
        push("rst2_mcause", K_RD, 12'h342, 32'h0);
        push("rst2_mstatus", K_RD, 12'h300, 32'h0);
        drain();
        step();
        push("rst2_mie", K_RD, 12'h304, 32'h0);
        push("rst2_cyc", K_RD, 12'hB00, 32'h0);
        push("rst2_cyc_hi", K_RD, 12'hB80, 32'h0);
        push("rst2_inst", K_RD, 12'hB02, 32'h0);
        push("rst2_req", K_REQ, 12'h000, 32'h0);
        drain();
        @(negedge clk_i);
        rst_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_unit_irq.md
Name: csr_unit_irq

Overview:
Parametrised machine-mode CSR file for the RISC-V core. It is the next generation of the single-width trap CSR block. It adds mstatus MIE/MPIE stacking, mret handling, a parametrised interrupt-pending/enable path with priority encoding, 64-bit mcycle/minstret counters and illegal-access flagging. It sits beside the decoder/PC logic: it accepts CSR ops from the execute stage, and supplies mtvec/mepc and an interrupt request to the trap controller.

Parameters:
XLEN, 32, data width of every CSR and data port.
IRQ_W, 16, number of external interrupt lines, 1..16; line k maps to mip/mie bit 16+k.
HAS_COUNTERS, 1, 1 = implement mcycle/minstret (and high halves); 0 = those addresses are unmapped.
MTVEC_RESET, 32'h0000_0000, reset value of mtvec.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
op_i  in  3  000 none, 001 write, 010 clear, 011 set, 1xx trap entry
addr_i  in  12  CSR address
wd_i  in  XLEN  write operand
pc_i  in  XLEN  PC of trapping instruction
mcause_i  in  XLEN  cause written on trap entry
mret_i  in  1  mret executing this cycle
instr_retired_i  in  1  one instruction retired this cycle
irq_i  in  IRQ_W  level-sensitive external interrupt lines
rd_o  out  XLEN  combinational read of addr_i
mepc_o  out  XLEN  current mepc
mtvec_o  out  XLEN  current mtvec
mie_o  out  XLEN  current mie
irq_req_o  out  1  enabled interrupt pending
irq_cause_o  out  XLEN  cause value for highest-priority pending interrupt
illegal_o  out  1  combinational: current op accesses an unmapped or read-only CSR

Behaviour:
- Map:
  - 0x300 mstatus: only bit3 MIE and bit7 MPIE are implemented; all other bits read 0.
  - 0x304 mie.
  - 0x305 mtvec: bits[1:0] read 0, direct mode only.
  - 0x340 mscratch.
  - 0x341 mepc: bits[1:0] read 0.
  - 0x342 mcause.
  - 0x344 mip: read-only.
  - 0xB00/0xB80 mcycle low/high; 0xB02/0xB82 minstret low/high. XLEN=32: high address = bits[63:32]. For XLEN=64 the high addresses are unmapped.
- Reset (rst_i high at edge): all CSRs 0 except mtvec=MTVEC_RESET; counters 0; mip 0. Outputs follow: rd_o reflects reset regs, irq_req_o=0.
- Read: rd_o is combinational from addr_i, zero latency. Unmapped address reads 0.
- Write data: 001 = wd_i; 010 = rd & ~wd_i (true bitwise clear); 011 = rd | wd_i. Takes effect at the next edge. Only implemented bits are stored; mie stores only bits 16..16+IRQ_W-1.
- illegal_o = op_i[2]==0 && op_i[1:0]!=0 && (addr unmapped || addr==0x344). An illegal write changes no state.
- Trap entry (op_i[2]=1), one edge:
  - mepc<=pc_i with [1:0]=0; mcause<=mcause_i.
  - MPIE<=MIE; MIE<=0.
  - addr_i/wd_i are ignored and no CSR write occurs that cycle.
- mret_i: MIE<=MPIE, MPIE<=1. Trap and mret in the same cycle: trap wins and mret is ignored. A CSR write to mstatus together with mret: mret wins for MIE/MPIE.
- mip[16+k] <= irq_i[k] every cycle (1-cycle registered sample, no latching).
- irq_req_o = MIE & |(mip & mie), combinational from registers, so a line asserted at edge N gives irq_req_o high after edge N+1.
- irq_cause_o = {1'b1, 0..., 16+k}, where k is the lowest-index pending & enabled line. It is 0 when none is pending.
- Counters (HAS_COUNTERS=1):
  - mcycle +1 every non-reset cycle; minstret +1 when instr_retired_i.
  - 64-bit wrap from all-ones to 0.
  - A CSR write to a half replaces that half and suppresses the increment for the whole counter that cycle; the other half holds.
  - A carry from low to high propagates in the same edge.

Test Plan:
- Reset then read 0x305 with MTVEC_RESET=32'h100 -> rd_o=32'h100. Read 0x300, 0x344, 0x341 -> 0. illegal_o=0 for reads (op 000).
- Write 0x340 with 32'hFFFF_00FF, then clear wd 32'h0000_000F, then set wd 32'h1234_0000 -> mscratch reads 32'hFFFF_00F0, then 32'hFFFF_00F0|32'h1234_0000 = 32'hFFFF_00F0.
- Set mstatus MIE (set 0x300, wd 8), then trap with pc_i=32'h0000_0203, mcause_i=32'h0000_000B -> mepc=32'h200, mcause=32'hB, mstatus=32'h80. Then mret -> mstatus=32'h88.
- mie=32'h000A_0000, MIE=1, irq_i=16'h000A -> two cycles later irq_req_o=1, irq_cause_o=32'h8000_0011. Clear mie bit 17 -> irq_cause_o=32'h8000_0013. Clear MIE -> irq_req_o=0.
- Write 0xB00 = 32'hFFFF_FFFE and 0xB80 = 0 in consecutive cycles, then idle 3 cycles -> mcycle low 0xFFFF_FFFF, then 0x0000_0000 with high incremented to 1. minstret is unchanged while instr_retired_i=0.
- Write op to 0x344 and to 0x7C0 -> illegal_o=1, no state change. rst_i asserted mid-sequence -> next cycle every CSR at reset value.
